// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts a 128-bit cipher key and streams round keys 0..10, one per cycle.
// Latency: round 0 appears on the cycle after the accepted start, round k k cycles later, done with round 10.
// No backpressure: the 11-cycle burst cannot be stalled; start is ignored while busy.

// One 32-bit SubWord: four parallel byte lookups, purely combinational.
module aes_sbox_word (
    input  logic [0:31] word_i,
    output logic [0:31] word_o
);
    // FIPS-197 S-box, byte x lives in bits [8x : 8x+7] (byte 0 leftmost).
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Substitute each byte of the word independently.
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[{word_i[8*b +: 8], 3'b000} +: 8];
        end
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [0:3]   round_idx,
    output logic [0:127] round_key,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [0:127]   key_q, key_d;       // current round key; also holds the latched cipher key
    logic [0:3]     idx_q, idx_d;       // round counter, doubles as round_idx
    logic [0:7]     rcon_q, rcon_d;     // Rcon for the round being computed next
    logic           busy_q, busy_d;
    logic           vld_q, vld_d;
    logic           done_q, done_d;

    // Next-round datapath: one S-box word followed by the XOR chain.
    logic [0:31]    p0, p1, p2, p3;
    logic [0:31]    rot_w, sub_w, t_w;
    logic [0:31]    n0, n1, n2, n3;
    logic [0:127]   next_key;
    logic [0:7]     rcon_next;

    assign p0 = key_q[0:31];
    assign p1 = key_q[32:63];
    assign p2 = key_q[64:95];
    assign p3 = key_q[96:127];

    assign rot_w = {p3[8:31], p3[0:7]};

    aes_sbox_word u_subword (
        .word_i (rot_w),
        .word_o (sub_w)
    );

    assign t_w      = sub_w ^ {rcon_q, 24'h000000};
    assign n0       = p0 ^ t_w;
    assign n1       = p1 ^ n0;
    assign n2       = p2 ^ n1;
    assign n3       = p3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // xtime in GF(2^8): bit 0 is the MSB, so it is the carry out of the shift.
    assign rcon_next = {rcon_q[1:7], 1'b0} ^ (rcon_q[0] ? 8'h1b : 8'h00);

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: latch the key on start, then advance one round per cycle until round 10 has been shown.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                key_d   = next_key;
                idx_d   = idx_q + 4'd1;
                rcon_d  = rcon_next;
                state_d = EXPAND;
            end
            EXPAND: begin
                if (idx_q == 4'd10) begin
                    // Round 10 has had its cycle; key and index stay frozen in IDLE.
                    busy_d  = 1'b0;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    key_d   = next_key;
                    idx_d   = idx_q + 4'd1;
                    rcon_d  = rcon_next;
                    done_d  = (idx_q == 4'd9);
                end
            end
            default: begin
                busy_d  = 1'b0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign rk_valid  = vld_q;
    assign round_idx = idx_q;
    assign round_key = key_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: random and directed key schedules against a GF(2^8) reference model.
// Expected round keys are queued at each predicted start acceptance; a negedge monitor compares every cycle.
// Runs a fixed number of cycles, plus a watchdog.
module tb_aes_key_expand;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] key_in;
    logic         busy;
    logic         rk_valid;
    logic [0:3]   round_idx;
    logic [0:127] round_key;
    logic         done;

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .round_idx (round_idx),
        .round_key (round_key),
        .done      (done)
    );

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        int           cyc;
        logic [127:0] key;
        int           idx;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           next_ok = 0;
    int           last_acc = -100;
    logic [127:0] last_key = '0;
    int           last_idx = 0;
    logic [7:0]   sbox_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] xb  = x[7:0];
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Full 44-word expansion; queue round r for observation at cycle e+r.
    task automatic accept(input int e, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                logic [7:0] rc = 8'h01;
                for (int k = 1; k < i / 4; k++) rc = gmul(rc, 8'h02);
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            if (key == A1_KEY && r == 1)  rk = A1_R1;
            if (key == A1_KEY && r == 10) rk = A1_R10;
            if (key == '0 && r == 1)      rk = Z_R1;
            if (key == '0 && r == 10)     rk = Z_R10;
            sb_q.push_back('{cyc: e + r, key: rk, idx: r});
        end
        last_acc = e;
        next_ok  = e + 12;
    endtask

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs and predict whether the coming edge accepts start.
    task automatic step(input bit s, input logic [127:0] k);
        @(negedge clk);
        start  = s;
        key_in = k;
        if (s && rst_n && (cyc + 1 >= next_ok)) accept(cyc + 1, k);
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  {127'd0, busy},      128'd0);
        chk({tag, "_valid"}, {127'd0, rk_valid},  128'd0);
        chk({tag, "_done"},  {127'd0, done},      128'd0);
        chk({tag, "_idx"},   {124'd0, round_idx}, 128'd0);
        chk({tag, "_key"},   round_key,           128'd0);
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        sb_q.delete();
        last_acc = -100;
        last_key = '0;
        last_idx = 0;
        start    = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        #2;
        rst_n   = 1'b1;
        next_ok = cyc + 1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        next_ok = cyc + 1;

        // A.1 run starting on the first edge after release, with key changes and an ignored start mid-run.
        step(1'b1, A1_KEY);
        step(1'b0, A1_KEY);
        step(1'b0, A1_KEY);
        step(1'b0, rnd_key());
        step(1'b0, rnd_key());
        step(1'b1, rnd_key());
        repeat (10) step(1'b0, rnd_key());

        // All-zero key.
        step(1'b1, '0);
        repeat (14) step(1'b0, rnd_key());

        // Start held high: back-to-back runs with one idle cycle between.
        repeat (24) step(1'b1, A1_KEY);
        repeat (14) step(1'b0, A1_KEY);

        // Reset in the middle of a run, then idle, then a fresh A.1 run.
        step(1'b1, A1_KEY);
        repeat (6) step(1'b0, A1_KEY);
        do_reset(3);
        repeat (5) step(1'b0, rnd_key());
        step(1'b1, A1_KEY);
        repeat (13) step(1'b0, rnd_key());

        // Random keys with random start pulses, including pulses while busy.
        repeat (150) step($urandom_range(0, 2) == 0, rnd_key());
        repeat (14) step(1'b0, rnd_key());

        @(negedge clk);
        chk("queue_drained", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit   exp_v;
                bit   busy_e;
                exp_t e;
                exp_v  = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
                busy_e = (cyc >= last_acc) && (cyc <= last_acc + 10);
                chk("rk_valid", {127'd0, rk_valid}, {127'd0, exp_v});
                chk("busy",     {127'd0, busy},     {127'd0, busy_e});
                if (exp_v) begin
                    e = sb_q.pop_front();
                    chk("round_key", round_key,           e.key);
                    chk("round_idx", {124'd0, round_idx}, 128'(e.idx));
                    chk("done",      {127'd0, done},      {127'd0, (e.idx == 10)});
                    last_key = e.key;
                    last_idx = e.idx;
                end else begin
                    chk("done_idle", {127'd0, done},      128'd0);
                    chk("hold_key",  round_key,           last_key);
                    chk("hold_idx",  {124'd0, round_idx}, 128'(last_idx));
                end
            end
        end
    end

    // Watchdog: the stimulus is a fixed-length script, so this only trips on a simulator-level hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cyc %0d, required completion earlier", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
